sync_fifo: RTL
==============

# sync_fifo

Single-clock, synchronous FIFO that sits directly downstream of the write-side interface: it accepts `write_en`/`data_in` from the write driver, reports `full` back to it, and presents a registered read port to the read-side agent. The default storage is 16 entries × 8 bits. It also provides occupancy, almost-full/almost-empty flags and overflow/underflow pulses for scoreboard checks. It is the DUT of the FIFO UVM environment.

## Interface
- `DATA_W`, 8, data width in bits.
- `DEPTH`, 16, number of entries; must be a power of 2 and ≥ 4.
- `AF_LVL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LVL.
- `AE_LVL`, 2, `almost_empty` asserts when count ≤ AE_LVL.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_en`  in  1  write request.
- `data_in`  in  DATA_W  write data; sampled when a write is accepted.
- `full`  out  1  count == DEPTH.
- `read_en`  in  1  read request.
- `data_out`  out  DATA_W  registered read data.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LVL.
- `almost_empty`  out  1  count ≤ AE_LVL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: write requested while full.
- `underflow`  out  1  one-cycle pulse: read requested while empty.

## Operation
- Accept rules:
  - wr_ok = write_en & ~full.
  - rd_ok = read_en & ~empty.
  - Both are evaluated on the current registered flags.
- On wr_ok:
  - mem[wr_ptr] ← data_in.
  - wr_ptr increments mod DEPTH; it wraps from DEPTH-1 to 0.
- On rd_ok:
  - data_out ← mem[rd_ptr].
  - rd_ptr increments mod DEPTH.
- When no read is accepted, data_out holds its last value.
- Count update: count ← count + wr_ok − rd_ok. Simultaneous accepted read and write leave count unchanged.
- Flags are decoded from the registered count (no lookahead):
  - `full`, `empty`, `almost_full`, `almost_empty`.
- Full with write_en & read_en both high:
  - the read is accepted;
  - the write is rejected;
  - overflow pulses;
  - count becomes DEPTH-1.
- Empty with write_en & read_en both high:
  - the write is accepted;
  - the read is rejected (no fall-through);
  - underflow pulses;
  - count becomes 1.
- Rejected operations do not change pointers, memory or count.
- Reset (sync, highest priority):
  - wr_ptr, rd_ptr and count ← 0;
  - data_out ← 0;
  - overflow and underflow ← 0.
  - Flags after reset: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared; they are unreachable.
  - A reset asserted mid-burst discards all stored data and ignores write_en/read_en in that cycle.

## Timing
- Write latency: a write accepted at edge N gives count+1 and updated flags after edge N.
  - The earliest read is read_en high in the cycle after N, accepted at edge N+1.
  - data_out is valid after edge N+1.
- Read latency: data_out changes on the same edge that accepts the read, i.e. 1 cycle after read_en is sampled.
- overflow/underflow:
  - registered;
  - high for exactly the cycle following the offending edge;
  - re-pulse every cycle the condition persists.
- No combinational path from inputs to any output.
- Writer handshake: the write driver samples `full` through its clocking block and must deassert write_en when full is seen. A write issued while full is dropped and flagged, never stored.

## Test plan
- Reset, then idle:
  - required: empty=1, almost_empty=1, full=0, count=0, data_out=0x00, no pulses.
- Write 0x01..0x10 (16 writes), then read 16:
  - full=1 and almost_full=1 after the 16th write (count=16);
  - almost_full first asserts at count=14;
  - reads return 0x01..0x10 in order;
  - empty=1 afterwards.
- Fill to 16, then one more write of 0xAA:
  - overflow pulses once;
  - count stays 16;
  - a full drain returns 0x01..0x10, with 0xAA absent.
- Read on empty:
  - underflow pulses;
  - data_out holds its previous value;
  - count stays 0.
- Wrap-around with simultaneous read/write:
  - preload 8 words;
  - run 40 cycles of write_en=read_en=1 with an incrementing pattern;
  - required: count stays 8 throughout, and output order matches input order across pointer wrap.
- Reset mid-operation:
  - with count=5, assert reset for 1 cycle while write_en=1;
  - required: count=0, empty=1, and the next write/read pair returns the new data only.

Source files
------------

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_if
//  Description : Handshake/bus bundle for sync_fifo. The write driver and the
//                read agent sit on the master side; the FIFO is the slave.
//                Signals:
//                  write_en, data_in            write request and data
//                  read_en                      read request
//                  full, empty                  occupancy extremes
//                  almost_full, almost_empty    threshold flags
//                  count                        occupancy 0..DEPTH
//                  data_out                     registered read data
//                  overflow, underflow          one-cycle error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                     write_en;
    logic [DATA_W-1:0]        data_in;
    logic                     full;
    logic                     read_en;
    logic [DATA_W-1:0]        data_out;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output write_en, data_in, read_en,
        input  full, data_out, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en,
        output full, data_out, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a registered read port, occupancy
//                count, almost-full/almost-empty thresholds and registered
//                overflow/underflow pulses.
//  Ports       : clk    - clock, all state changes on the rising edge
//                reset  - synchronous active-high reset
//                bus    - sync_fifo_if.slave (write/read handshake, flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    sync_fifo_if.slave    bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ok;
    logic               w_rd_ok;

    // Flags come straight from the registered count, so there is no path
    // from write_en/read_en to any output.
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Accept decisions use the current flags only: a full FIFO refuses a
    // write even if a read frees a slot on the same edge, and an empty FIFO
    // never lets a same-cycle write fall through to the read port.
    assign w_wr_ok = bus.write_en & ~w_full;
    assign w_rd_ok = bus.read_en  & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.write_en & w_full;
            r_underflow <= bus.read_en  & w_empty;

            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end

            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers
    // and count are cleared. Writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_CNT_W'(AF_LVL));
    assign bus.almost_empty = (r_count <= c_CNT_W'(AE_LVL));
    assign bus.count        = r_count;
    assign bus.data_out     = r_data_out;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire
